// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver.
// Receiver FSM state encodings.
package serial_frame_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/serial_bit_timer.sv
// Loadable down-counter pacing serial bit sampling.
// Expires in the cycle the count sits at 0 while enabled.
module serial_bit_timer #(
   parameter int W = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] count;

   // Load takes priority; otherwise count down and park at 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expire = en & (count == '0);

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, LSB-first data, optional
// even parity, stop; words delivered on valid/ready.
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BIT_CYCLES = 4,
   parameter int PARITY_EN  = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  serial_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  overrun
);

   localparam int TW = $clog2(BIT_CYCLES);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [TW-1:0] HALF = TW'(BIT_CYCLES / 2 - 1);
   localparam logic [TW-1:0] FULL = TW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   rx_state_t             state, state_nx;
   logic                  prev;
   logic                  tmr_en, tmr_load, expire;
   logic [TW-1:0]         tmr_val;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH:0]   shift_ext;
   logic                  par_bad, stop_ok, done;

   assign tmr_en    = (state != ST_IDLE);
   assign shift_ext = {serial_in, shift_q};

   serial_bit_timer #(.W(TW)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .en       (tmr_en),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (expire)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // Next state and timer reload decisions.
   always_comb begin
      state_nx = state;
      tmr_load = 1'b0;
      tmr_val  = FULL;
      case (state)
         ST_IDLE: begin
            if (prev && !serial_in) begin
               state_nx = ST_START;
               tmr_load = 1'b1;
               tmr_val  = HALF;
            end
         end
         ST_START: begin
            if (expire) begin
               if (!serial_in) begin
                  state_nx = ST_DATA;
                  tmr_load = 1'b1;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (expire) begin
               tmr_load = 1'b1;
               if (bit_cnt == LAST)
                  state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (expire) begin
               tmr_load = 1'b1;
               state_nx = ST_STOP;
            end
         end
         ST_STOP: begin
            if (expire) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Edge detect, shift register, parity and stop capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev    <= 1'b1;
         bit_cnt <= '0;
         shift_q <= '0;
         par_bad <= 1'b0;
         stop_ok <= 1'b0;
         done    <= 1'b0;
      end else begin
         prev <= serial_in;
         done <= 1'b0;
         case (state)
            ST_START: begin
               bit_cnt <= '0;
               par_bad <= 1'b0;
            end
            ST_DATA: begin
               if (expire) begin
                  shift_q <= shift_ext[DATA_WIDTH:1];
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_PARITY: begin
               if (expire) par_bad <= (^shift_q) ^ serial_in;
            end
            ST_STOP: begin
               if (expire) begin
                  stop_ok <= serial_in;
                  done    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Frame completion: deliver, drop on overrun, or flag errors.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
         if (data_valid && data_ready) data_valid <= 1'b0;
         if (done) begin
            if (!stop_ok) begin
               frame_err  <= 1'b1;
               parity_err <= par_bad;
            end else if (par_bad) begin
               parity_err <= 1'b1;
            end else if (!data_valid || data_ready) begin
               data_out   <= shift_q;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (default params).
// Scoreboard of expected words, popped on each handshake.
module tb_serial_frame_rx;

   localparam int BC = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       serial_in = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready = 1'b1;
   logic       frame_err, parity_err, overrun;

   serial_frame_rx dut (
      .clock      (clock),
      .reset      (reset),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always #5 clock = ~clock;

   int n_chk = 0, n_pass = 0;
   int cyc = 0, start_cyc = 0, lat = -1;
   int fe_n = 0, pe_n = 0, ov_n = 0, dv_n = 0;
   int fe0, pe0, ov0, dv0;
   logic dv_q = 1'b0;
   int exp_q[$];

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic sample();
      if (!reset) begin
         if (frame_err)  fe_n++;
         if (parity_err) pe_n++;
         if (overrun)    ov_n++;
         if (data_valid) dv_n++;
         if (data_valid && !dv_q) lat = cyc - start_cyc;
         if (data_valid && data_ready) begin
            if (exp_q.size() == 0)
               chk("sb_underflow", exp_q.size(), 1);
            else
               chk("word", int'(data_out), exp_q.pop_front());
         end
         dv_q = data_valid;
      end else begin
         dv_q = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clock);
      sample();
      @(posedge clock);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      serial_in = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      serial_in = b;
      repeat (BC) tick();
   endtask

   task automatic send_frame(input logic [7:0] d,
                             input logic flip,
                             input logic stop);
      start_cyc = cyc + 1;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((^d) ^ flip);
      send_bit(stop);
   endtask

   task automatic snap();
      fe0 = fe_n; pe0 = pe_n; ov0 = ov_n; dv0 = dv_n;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_valid", data_valid, 0);
      chk("rst_data", data_out, 0);
      chk("rst_pulses", {frame_err, parity_err, overrun}, 0);
      reset = 1'b0;
      idle(4);

      // 1: good frame, latency and single-cycle valid
      snap();
      lat = -1;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1);
      idle(8);
      chk("t1_latency", lat, 43);
      chk("t1_valid_cycles", dv_n - dv0, 1);
      chk("t1_errs", (fe_n - fe0) + (pe_n - pe0) + (ov_n - ov0), 0);

      // 2: parity error
      snap();
      send_frame(8'h3C, 1'b1, 1'b1);
      idle(8);
      chk("t2_perr", pe_n - pe0, 1);
      chk("t2_ferr", fe_n - fe0, 0);
      chk("t2_valid", dv_n - dv0, 0);

      // 3: framing error, then a good frame
      snap();
      send_frame(8'h81, 1'b0, 1'b0);
      // line returns high so the next start bit forms an edge
      send_bit(1'b1);
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b0, 1'b1);
      idle(8);
      chk("t3_ferr", fe_n - fe0, 1);
      chk("t3_perr", pe_n - pe0, 0);
      chk("t3_valid", dv_n - dv0, 1);

      // 4: overrun while a word is held
      snap();
      data_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      idle(8);
      chk("t4_overrun", ov_n - ov0, 1);
      chk("t4_held", data_out, 8'h11);
      chk("t4_valid", data_valid, 1);
      data_ready = 1'b1;
      idle(3);
      chk("t4_drop", data_valid, 0);

      // 5: one-cycle glitch is rejected, receiver still works
      snap();
      serial_in = 1'b0;
      tick();
      idle(12);
      chk("t5_valid", dv_n - dv0, 0);
      chk("t5_errs", (fe_n - fe0) + (pe_n - pe0) + (ov_n - ov0), 0);
      exp_q.push_back(8'h33);
      send_frame(8'h33, 1'b0, 1'b1);
      idle(8);
      chk("t5_after", dv_n - dv0, 1);

      // 6: reset mid-frame with a word held
      data_ready = 1'b0;
      send_frame(8'h99, 1'b0, 1'b1);
      idle(8);
      chk("t6_held", data_valid, 1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      serial_in = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", data_valid, 0);
      chk("t6_rst_data", data_out, 0);
      chk("t6_rst_pulses", {frame_err, parity_err, overrun}, 0);
      data_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      idle(4);
      snap();
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 1'b1);
      idle(8);
      chk("t6_valid", dv_n - dv0, 1);
      chk("t6_errs", (fe_n - fe0) + (pe_n - pe0) + (ov_n - ov0), 0);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      chk("sb_drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
